enemy_sprite_ctrl: RTL
======================

Name: enemy_sprite_ctrl

Overview:
- Controller for the enemy sprite RAM: a single-clock RAM with one read port, one write port, 12-bit colour and a 1-cycle registered read.
- Read side: converts the VGA scan position into sprite-RAM read addresses and emits a pipelined, chroma-keyed pixel with a valid flag for the pixel mux.
- Write side: sequences host sprite-update writes so they reach the RAM only during vertical blanking (no tearing).
- Position: latches host position updates into a shadow register and applies them at frame start.

Parameters:
- DATA_WIDTH, 12, colour depth; matches the RAM data width.
- ADDR_WIDTH, 12, RAM address bits.
- SPR_W_BITS, 6, log2 sprite width (64 px); sprite height = 2**(ADDR_WIDTH-SPR_W_BITS) = 64.
- KEY_COLOR, 12'hF0F, transparent colour.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- x  in  11  current pixel column
- y  in  11  current pixel row
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- vblank  in  1  high during vertical blanking
- pos_wr  in  1  strobe: capture pos_x, pos_y, vis_in, flip_in into shadow registers
- pos_x  in  11  sprite left edge
- pos_y  in  11  sprite top edge
- vis_in  in  1  sprite visible
- flip_in  in  1  horizontal mirror request (used only with the macro)
- wr_req  in  1  host sprite-write request
- wr_addr  in  ADDR_WIDTH  host write address
- wr_data  in  DATA_WIDTH  host write data
- wr_ack  out  1  one-cycle pulse when the write is committed to the RAM
- busy  out  1  write pending
- ram_addr_r  out  ADDR_WIDTH  RAM read address (combinational)
- ram_dout  in  DATA_WIDTH  RAM registered read data
- ram_we  out  1  RAM write enable
- ram_addr_w  out  ADDR_WIDTH  RAM write address
- ram_din  out  DATA_WIDTH  RAM write data
- rgb  out  DATA_WIDTH  sprite pixel colour
- en  out  1  sprite pixel valid (inside sprite and not transparent)

Behaviour:
- Reset values: rgb=0, en=0, wr_ack=0, busy=0, ram_we=0; shadow and active registers all 0 (vis=0, so sprite hidden); write FSM=IDLE.
- Position double-buffer:
  - pos_wr loads the shadow registers.
  - frame_start copies shadow to active.
  - pos_wr and frame_start in the same cycle: active takes the OLD shadow; the new value lands in the shadow only.
- Hit test: computed in 12-bit unsigned so the sprite's right/bottom edge can pass 2047 without wrap.
  - hit = act_vis & x>=act_x & x<act_x+W & y>=act_y & y<act_y+H.
- Read address: ram_addr_r = {(y-act_y)[H bits], (x-act_x)[SPR_W_BITS bits]}, combinational.
  - When hit=0, ram_addr_r is don't-care and driven to 0.
- Read pipeline, latency 2 clocks from x/y:
  - Edge k: RAM registers data; hit is registered as hit_d.
  - Edge k+1: rgb <= ram_dout; en <= hit_d & (ram_dout != KEY_COLOR).
  - When en=0, rgb=0.
- Write FSM, states IDLE, HOLD, COMMIT:
  - IDLE: on wr_req, capture wr_addr and wr_data, go to HOLD; busy=1 from the next cycle.
  - HOLD: when vblank=1, go to COMMIT.
  - COMMIT (exactly one cycle): ram_we=1 with the captured address/data, wr_ack=1; then IDLE, busy=0.
  - wr_req while busy=1 is ignored; the host must wait for wr_ack.
  - wr_req arriving during vblank still takes IDLE, HOLD, COMMIT, i.e. 2 cycles to ack.
  - vblank falling while in HOLD: keep waiting for the next vblank.
  - Reset in HOLD or COMMIT: pending write is dropped, no wr_ack, no RAM write.
- Read and write ports are independent; a same-address read/write collision returns old data, as the RAM defines.

Optional Feature:
- Macro: ENEMY_MIRROR_EN.
- Defined: active flip register (loaded through the shadow like position); when set, the x offset becomes (W-1)-(x-act_x).
- Undefined: flip_in is ignored, no flip register is built, and the x offset is never mirrored.

Test Plan:
- Reset, then pos_wr with (100,50,vis=1), no frame_start -> en stays 0 for a full scan line; after frame_start, x=100,y=50 gives ram_addr_r=0x000 and en=1 two clocks later.
- Active pos (100,50), scan x=163,y=113 -> ram_addr_r=0xFFF; x=164 -> en=0 two clocks later; x=99 -> en=0.
- RAM word at 0x041 = 12'hF0F, pixel (101,51) -> en=0, rgb=0; RAM word = 12'h123 -> en=1, rgb=12'h123.
- wr_req addr=0x010 data=0xABC with vblank=0 -> busy=1, ram_we stays 0 for 500 cycles; raise vblank -> ram_we=1 and wr_ack=1 exactly one cycle, then busy=0; second wr_req while busy -> no extra ack.
- Reset asserted while in HOLD -> no ram_we and no wr_ack afterwards, busy=0; pos_wr and frame_start in the same cycle -> active shows the previous shadow value.
- With ENEMY_MIRROR_EN and flip_in=1 at pos 100, x=100 -> ram_addr_r low 6 bits = 63; without the macro -> 0.

Source files
------------

// File: rtl/enemy_sprite_ctrl.sv
// enemy_sprite_ctrl: sprite-RAM read addressing with a chroma-keyed pixel
// pipeline, vblank-gated host write sequencing, and a frame-synchronous
// double-buffered sprite position.
// Optional macro ENEMY_MIRROR_EN adds a horizontal-mirror (flip) register.
//
// Write FSM states:
//   state    | meaning
//   S_IDLE   | no write pending; accepts wr_req
//   S_HOLD   | write captured, waiting for vblank
//   S_COMMIT | single cycle driving ram_we / wr_ack
module enemy_sprite_ctrl #(
  parameter int                    DATA_WIDTH = 12,
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    SPR_W_BITS = 6,
  parameter logic [DATA_WIDTH-1:0] KEY_COLOR  = 12'hF0F
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic                  frame_start,
  input  logic                  vblank,
  input  logic                  pos_wr,
  input  logic [10:0]           pos_x,
  input  logic [10:0]           pos_y,
  input  logic                  vis_in,
  input  logic                  flip_in,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_addr_r,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_w,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [DATA_WIDTH-1:0] rgb,
  output logic                  en
);

  localparam int          SPR_H_BITS = ADDR_WIDTH - SPR_W_BITS;
  localparam logic [11:0] SPR_W      = 12'(2 ** SPR_W_BITS);
  localparam logic [11:0] SPR_H      = 12'(2 ** SPR_H_BITS);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_COMMIT} wr_state_t;

  logic [10:0] r_sh_x, r_sh_y, r_act_x, r_act_y;
  logic        r_sh_vis, r_act_vis;
  logic        r_hit_d, r_en;
  logic [DATA_WIDTH-1:0] r_rgb;
  wr_state_t   r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;

  logic [11:0] w_x12, w_y12, w_ax12, w_ay12, w_ax_end, w_ay_end;
  logic        w_hit, w_en_nxt;
  logic [SPR_W_BITS-1:0] w_dx, w_xo;
  logic [SPR_H_BITS-1:0] w_dy;

`ifdef ENEMY_MIRROR_EN
  logic r_sh_flip, r_act_flip;

  // Flip bit follows the same shadow/active path as the position.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_flip  <= 1'b0;
      r_act_flip <= 1'b0;
    end else begin
      if (frame_start) r_act_flip <= r_sh_flip;
      if (pos_wr)      r_sh_flip  <= flip_in;
    end
  end

  assign w_xo = r_act_flip ? ~w_dx : w_dx;
`else
  logic w_unused_flip;
  assign w_unused_flip = flip_in;
  assign w_xo          = w_dx;
`endif

  // Shadow takes host updates; active copies the pre-update shadow at frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_x    <= '0;
      r_sh_y    <= '0;
      r_sh_vis  <= 1'b0;
      r_act_x   <= '0;
      r_act_y   <= '0;
      r_act_vis <= 1'b0;
    end else begin
      if (frame_start) begin
        r_act_x   <= r_sh_x;
        r_act_y   <= r_sh_y;
        r_act_vis <= r_sh_vis;
      end
      if (pos_wr) begin
        r_sh_x   <= pos_x;
        r_sh_y   <= pos_y;
        r_sh_vis <= vis_in;
      end
    end
  end

  // 12-bit compare so a sprite hanging past column/row 2047 does not wrap.
  assign w_x12    = {1'b0, x};
  assign w_y12    = {1'b0, y};
  assign w_ax12   = {1'b0, r_act_x};
  assign w_ay12   = {1'b0, r_act_y};
  assign w_ax_end = w_ax12 + SPR_W;
  assign w_ay_end = w_ay12 + SPR_H;
  assign w_hit    = r_act_vis && (w_x12 >= w_ax12) && (w_x12 < w_ax_end)
                    && (w_y12 >= w_ay12) && (w_y12 < w_ay_end);

  // Only the low offset bits matter once hit is known.
  assign w_dx       = x[SPR_W_BITS-1:0] - r_act_x[SPR_W_BITS-1:0];
  assign w_dy       = y[SPR_H_BITS-1:0] - r_act_y[SPR_H_BITS-1:0];
  assign ram_addr_r = w_hit ? {w_dy, w_xo} : '0;

  assign w_en_nxt = r_hit_d && (ram_dout != KEY_COLOR);

  // Hit is delayed to line up with the RAM's registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_d <= 1'b0;
      r_en    <= 1'b0;
      r_rgb   <= '0;
    end else begin
      r_hit_d <= w_hit;
      r_en    <= w_en_nxt;
      r_rgb   <= w_en_nxt ? ram_dout : '0;
    end
  end

  assign en  = r_en;
  assign rgb = r_rgb;

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Write FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (wr_req) w_state_nxt = S_HOLD;
      S_HOLD:   if (vblank) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Captured only when idle, so requests while busy cannot disturb a pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (r_state == S_IDLE && wr_req) begin
      r_wr_addr <= wr_addr;
      r_wr_data <= wr_data;
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign ram_we     = (r_state == S_COMMIT);
  assign wr_ack     = (r_state == S_COMMIT);
  assign ram_addr_w = r_wr_addr;
  assign ram_din    = r_wr_data;

endmodule
